// File: rtl/tank_level_pkg.sv
// Shared types and pattern helpers for the tank level monitor.
package tank_level_pkg;

   typedef enum logic [2:0] {
      EMPTY = 3'd0,
      LOW   = 3'd1,
      MID   = 3'd2,
      FULL  = 3'd3,
      FAULT = 3'd4
   } level_state_t;

   // Debounced pattern {high, mid, low}; only bottom-up wet columns are physical
   localparam logic [2:0] PAT_EMPTY = 3'b000;
   localparam logic [2:0] PAT_LOW   = 3'b001;
   localparam logic [2:0] PAT_MID   = 3'b011;
   localparam logic [2:0] PAT_FULL  = 3'b111;

   function automatic logic pat_valid(input logic [2:0] p);
      return (p == PAT_EMPTY) || (p == PAT_LOW) || (p == PAT_MID) || (p == PAT_FULL);
   endfunction

   function automatic logic [1:0] pat_level(input logic [2:0] p);
      case (p)
         PAT_LOW:  return 2'd1;
         PAT_MID:  return 2'd2;
         PAT_FULL: return 2'd3;
         default:  return 2'd0;
      endcase
   endfunction

endpackage

// File: rtl/sensor_debouncer.sv
// Two-flop synchroniser followed by a stability counter for one float sensor.
module sensor_debouncer
   import tank_level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic i_raw,
   output logic o_deb
);

   localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

   logic       r_sync1;
   logic       r_sync2;
   logic       r_deb;
   logic [7:0] r_cnt;

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_deb   <= 1'b0;
         r_cnt   <= 8'd0;
      end else begin
         r_sync1 <= i_raw;
         r_sync2 <= r_sync1;
         if (r_sync2 == r_deb) begin
            r_cnt <= 8'd0;
         end else if (r_cnt == CNT_MAX) begin
            r_deb <= r_sync2;
            r_cnt <= 8'd0;
         end else begin
            r_cnt <= r_cnt + 8'd1;
         end
      end
   end

   assign o_deb = r_deb;

endmodule

// File: rtl/tank_level_monitor.sv
// Tank level classifier: debounced floats -> level FSM with fault qualification.
// Define ERROR_LATCH_EN to make FAULT sticky until clear_i with a valid pattern.
module tank_level_monitor
   import tank_level_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = 16,
   parameter int ERR_HOLD        = 8
) (
   input  logic       clk_i,
   input  logic       rst_n_i,
   input  logic       sensor_low_i,
   input  logic       sensor_mid_i,
   input  logic       sensor_high_i,
   input  logic       clear_i,
   output logic       low_level_indicator_o,
   output logic       error_indicator_o,
   output logic [1:0] level_o
);

   localparam logic [7:0] ERR_MAX = 8'(ERR_HOLD);

   logic [2:0]   w_raw;
   logic [2:0]   w_pat;
   logic         w_valid;
   logic         w_release;
   logic [7:0]   r_err_cnt;
   level_state_t r_state;
   level_state_t w_next;
   logic         r_low_ind;
   logic         r_err;
   logic [1:0]   r_level;

   assign w_raw = {sensor_high_i, sensor_mid_i, sensor_low_i};

   for (genvar g = 0; g < 3; g++) begin : g_deb
      sensor_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_deb (
         .clk_i  (clk_i),
         .rst_n_i(rst_n_i),
         .i_raw  (w_raw[g]),
         .o_deb  (w_pat[g])
      );
   end

   assign w_valid = pat_valid(w_pat);

`ifdef ERROR_LATCH_EN
   assign w_release = clear_i;
`else
   logic w_unused_clear;
   assign w_unused_clear = clear_i;
   assign w_release      = 1'b1;
`endif

   // Saturating run length of invalid patterns
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)              r_err_cnt <= 8'd0;
      else if (w_valid)          r_err_cnt <= 8'd0;
      else if (r_err_cnt != ERR_MAX) r_err_cnt <= r_err_cnt + 8'd1;
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) r_state <= EMPTY;
      else          r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_valid) begin
         if ((r_state != FAULT) || w_release)
            w_next = level_state_t'({1'b0, pat_level(w_pat)});
      end else if (r_err_cnt == ERR_MAX) begin
         w_next = FAULT;
      end
   end

   // Level code freezes during FAULT so the controller keeps the last good reading
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         r_low_ind <= 1'b0;
         r_err     <= 1'b0;
         r_level   <= 2'd0;
      end else begin
         r_low_ind <= (r_state == LOW) || (r_state == MID) || (r_state == FULL);
         r_err     <= (r_state == FAULT);
         if (r_state != FAULT) r_level <= r_state[1:0];
      end
   end

   assign low_level_indicator_o = r_low_ind;
   assign error_indicator_o     = r_err;
   assign level_o               = r_level;

endmodule

// File: tb/tb_tank_level_monitor.sv
// Self-checking bench: directed latency/fault sequences, a vector table and randomized model check.
module tb_tank_level_monitor;

   localparam int D = 16;
   localparam int H = 8;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       s_low = 1'b0, s_mid = 1'b0, s_high = 1'b0, clr = 1'b0;
   logic       li, er;
   logic [1:0] lvl;

   int n_vec = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   tank_level_monitor #(.DEBOUNCE_CYCLES(D), .ERR_HOLD(H)) dut (
      .clk_i                (clk),
      .rst_n_i              (rst_n),
      .sensor_low_i         (s_low),
      .sensor_mid_i         (s_mid),
      .sensor_high_i        (s_high),
      .clear_i              (clr),
      .low_level_indicator_o(li),
      .error_indicator_o    (er),
      .level_o              (lvl)
   );

   // Reference model: each sensor is accepted once its synchronised value has
   // disagreed with the accepted one for D samples in a row; a tank reading is
   // physical when the wet sensors form a solid column from the bottom.
   bit [2:0] m_s1, m_s2, m_deb;
   int       m_run[3];
   int       m_bad;
   int       m_state;  // 0..3 = level, 4 = fault
   bit       m_li, m_er;
   bit [1:0] m_lv;

   function automatic bit phys(bit [2:0] p);
      return ((p + 3'd1) & p) == 3'd0;
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m_s1 = '0; m_s2 = '0; m_deb = '0;
         for (int i = 0; i < 3; i++) m_run[i] = 0;
         m_bad = 0; m_state = 0;
         m_li = 0; m_er = 0; m_lv = 0;
      end else begin
         bit ok, rel;
         m_li = (m_state >= 1) && (m_state <= 3);
         m_er = (m_state == 4);
         if (m_state != 4) m_lv = 2'(m_state);
`ifdef ERROR_LATCH_EN
         rel = clr;
`else
         rel = 1'b1;
`endif
         ok = phys(m_deb);
         if (ok) begin
            if (m_state != 4 || rel) m_state = $countones(m_deb);
         end else if (m_bad >= H) begin
            m_state = 4;
         end
         m_bad = ok ? 0 : m_bad + 1;
         for (int i = 0; i < 3; i++) begin
            if (m_s2[i] != m_deb[i]) begin
               m_run[i]++;
               if (m_run[i] == D) begin
                  m_deb[i] = m_s2[i];
                  m_run[i] = 0;
               end
            end else begin
               m_run[i] = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = {s_high, s_mid, s_low};
      end
   end

   task automatic chk(input string nm, input bit e_li, input bit e_er, input bit [1:0] e_lv);
      n_vec++;
      if ({li, er, lvl} !== {e_li, e_er, e_lv}) begin
         n_err++;
         $display("FAIL %s @%0t: got li=%0b err=%0b lvl=%0d, want li=%0b err=%0b lvl=%0d",
                  nm, $time, li, er, lvl, e_li, e_er, e_lv);
      end
   endtask

   task automatic chk_m(input string nm);
      chk(nm, m_li, m_er, m_lv);
   endtask

   task automatic set_pat(input bit [2:0] p);
      s_high = p[2]; s_mid = p[1]; s_low = p[0];
   endtask

   typedef struct {
      bit [2:0] pat;
      int       hold;
      bit       li;
      bit       er;
      bit [1:0] lv;
   } vec_t;

   vec_t tbl[7];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: bench did not finish, got timeout, want $finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0] = '{3'b001, 25, 1'b1, 1'b0, 2'd1};
      tbl[1] = '{3'b011, 25, 1'b1, 1'b0, 2'd2};
      tbl[2] = '{3'b111, 25, 1'b1, 1'b0, 2'd3};
      tbl[3] = '{3'b000, 25, 1'b0, 1'b0, 2'd0};
      tbl[4] = '{3'b011, 25, 1'b1, 1'b0, 2'd2};
      tbl[5] = '{3'b110, 40, 1'b0, 1'b1, 2'd2};
`ifdef ERROR_LATCH_EN
      tbl[6] = '{3'b111, 25, 1'b0, 1'b1, 2'd2};
`else
      tbl[6] = '{3'b111, 25, 1'b1, 1'b0, 2'd3};
`endif

      // Reset state, quiet sensors
      #17 rst_n = 1'b1;
      @(negedge clk);
      for (int k = 0; k < 30; k++) begin
         @(negedge clk);
         chk("reset_idle", 0, 0, 0);
      end

      // Exact latency of a clean low-sensor edge
      s_low = 1'b1;
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         if (k < 19) chk("lat_pre", 0, 0, 0);
         else        chk("lat_19", 1, 0, 1);
      end

      // Mid glitches of 1 and 15 cycles are rejected
      s_mid = 1'b1; @(negedge clk); s_mid = 1'b0;
      for (int k = 0; k < 25; k++) begin @(negedge clk); chk("glitch1", 1, 0, 1); end
      s_mid = 1'b1; repeat (15) @(negedge clk); s_mid = 1'b0;
      for (int k = 0; k < 25; k++) begin @(negedge clk); chk("glitch15", 1, 0, 1); end
      s_mid = 1'b1;
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         if (k < 19) chk("mid_pre", 1, 0, 1);
         else        chk("mid_19", 1, 0, 2);
      end

      // High-only pattern: fault qualified after ERR_HOLD extra cycles
      set_pat(3'b100);
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (k < 19 + H) chk("fault_pre", 1, 0, 2);
         else            chk("fault_on", 0, 1, 2);
      end
`ifdef ERROR_LATCH_EN
      clr = 1'b1; @(negedge clk); clr = 1'b0;
      for (int k = 0; k < 3; k++) begin @(negedge clk); chk("clr_invalid", 0, 1, 2); end
      set_pat(3'b111);
      for (int k = 0; k < 30; k++) begin @(negedge clk); chk("latched", 0, 1, 2); end
      clr = 1'b1; @(negedge clk); clr = 1'b0;
      chk("clr_edge", 0, 1, 2);
      @(negedge clk);
      chk("clr_done", 1, 0, 3);
`else
      set_pat(3'b111);
      for (int k = 0; k <= 19; k++) begin
         @(negedge clk);
         if (k < 19) chk("recover_pre", 0, 1, 2);
         else        chk("recover_19", 1, 0, 3);
      end
`endif

      // Async reset while in FAULT with a debounce in flight
      set_pat(3'b100);
      repeat (30) @(negedge clk);
      chk("fault_again", 0, 1, 3);
      s_low = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #3 rst_n = 1'b0;
      set_pat(3'b000);
      #1 chk("async_rst", 0, 0, 0);
      @(negedge clk); chk("rst_hold", 0, 0, 0);
      @(negedge clk); rst_n = 1'b1;

      // Table of steady patterns
      for (int i = 0; i < 7; i++) begin
         set_pat(tbl[i].pat);
         repeat (tbl[i].hold) @(negedge clk);
         chk($sformatf("tbl%0d", i), tbl[i].li, tbl[i].er, tbl[i].lv);
         chk_m($sformatf("tbl%0d_model", i));
      end

      // Randomized segments compared cycle by cycle against the model
      for (int seg = 0; seg < 120; seg++) begin
         bit [2:0] p;
         int       hold;
         if ($urandom_range(0, 9) < 7) begin
            case ($urandom_range(0, 3))
               0: p = 3'b000;
               1: p = 3'b001;
               2: p = 3'b011;
               default: p = 3'b111;
            endcase
         end else begin
            p = 3'($urandom_range(0, 7));
         end
         hold = $urandom_range(1, 45);
         set_pat(p);
         for (int k = 0; k < hold; k++) begin
            clr = ($urandom_range(0, 7) == 0);
            @(negedge clk);
            chk_m("random");
         end
      end
      clr = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/tank_level_monitor.md
Name: tank_level_monitor

Overview:
- Upstream stage of the irrigation alarm path. Consumes three raw water-tank float sensors (low, mid, high).
- Synchronises and debounces each sensor, classifies tank level with a state machine and flags physically impossible sensor combinations.
- Drives the low-level indicator and error indicator that feed the alarm trigger, plus a 2-bit level code for the irrigation controller.

Parameters:
- DEBOUNCE_CYCLES, 16: consecutive stable synchronised cycles required before a sensor value is accepted; legal range 2..255.
- ERR_HOLD, 8: consecutive cycles an invalid debounced pattern must persist before the error is raised; legal range 1..255.

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- sensor_low_i  input  1  raw low float; 1 = wet
- sensor_mid_i  input  1  raw mid float; 1 = wet
- sensor_high_i  input  1  raw high float; 1 = wet
- clear_i  input  1  error acknowledge pulse; used only with ERROR_LATCH_EN
- low_level_indicator_o  output  1  1 = water above low sensor (safe); 0 = critical
- error_indicator_o  output  1  1 = sensor fault
- level_o  output  2  0 = EMPTY, 1 = LOW, 2 = MID, 3 = FULL; holds last valid value during FAULT

Behaviour:
- Interface: one clock, clk_i. Reset rst_n_i is asynchronous, active-low.
- Reset values:
  - All sync flops, debounced values and counters = 0.
  - State = EMPTY.
  - low_level_indicator_o = 0 (fail-safe: alarm active until sensors are qualified).
  - error_indicator_o = 0, level_o = 0.
- Per sensor:
  - 2-flop synchroniser feeds a counter.
  - Counter clears whenever the synchronised value equals the debounced value.
  - Otherwise the counter increments. On reaching DEBOUNCE_CYCLES-1, the debounced value takes the synchronised value and the counter clears.
  - A glitch shorter than DEBOUNCE_CYCLES never propagates.
- Pattern P = {high, mid, low} from the debounced values.
  - Valid patterns: 000, 001, 011, 111.
  - All other patterns are invalid (a wet upper sensor with a dry lower sensor).
- States: EMPTY, LOW, MID, FULL, FAULT.
  - Valid P moves the FSM to the matching level state next cycle. Any level may jump to any level; no ordering is enforced.
  - Invalid P increments the error counter, saturating at ERR_HOLD. Entry to FAULT occurs on the cycle the counter reaches ERR_HOLD.
  - Valid P clears the error counter.
  - Before ERR_HOLD is reached, the FSM stays in its last level state.
- Outputs are registered, decoded from the state register:
  - low_level_indicator_o = 1 only in LOW, MID or FULL.
  - error_indicator_o = 1 only in FAULT.
  - level_o updates only in level states.
- Latency: a clean raw edge appears on the outputs exactly 2 + DEBOUNCE_CYCLES + 1 cycles after the first sampling edge.
- FAULT exit without the macro: the first cycle P is valid, the FSM moves to the matching level state and the error drops next cycle.
- Simultaneous sensor changes: sensors debounce independently. Transient invalid patterns shorter than ERR_HOLD cause no error.
- Reset mid-operation: everything returns to reset values immediately, including a latched fault.

Optional Feature:
- ERROR_LATCH_EN defined:
  - FAULT is sticky. Exit only when clear_i = 1 in a cycle where P is valid; the FSM then goes to the matching level state.
  - clear_i with P still invalid is ignored.
- ERROR_LATCH_EN undefined: clear_i is unused and FAULT auto-clears as described above.

Decomposition:
- Package tank_level_pkg:
  - level_state_t enum (EMPTY=0, LOW=1, MID=2, FULL=3, FAULT=4; 3 bits).
  - Valid-pattern constants.
  - Helper function mapping a valid pattern to its 2-bit level code.
- Sub-module sensor_debouncer, instantiated three times. Contains the synchroniser plus counter; parameter DEBOUNCE_CYCLES.

Test Plan:
- Reset, all sensors 0, hold 30 cycles -> low_level_indicator_o = 0, error_indicator_o = 0, level_o = 0 throughout.
- sensor_low_i 0->1 at cycle 0 -> low_level_indicator_o = 1 and level_o = 1 exactly at cycle 19; no earlier change.
- sensor_mid_i 1-cycle and 15-cycle pulses with low wet -> level_o stays 1. A 16-cycle hold -> level_o = 2 at cycle 19.
- Force P = 100 (high only) held 40 cycles -> error_indicator_o = 1 at cycle 19+8 = 27, low_level_indicator_o = 0. Restore 111 -> without macro, error clears and level_o = 3 after 19 cycles.
- With ERROR_LATCH_EN: same fault, restore 111 -> error stays 1. Pulse clear_i -> error 0, level_o = 3 next cycle. clear_i while P invalid -> no effect.
- Assert rst_n_i low asynchronously mid-debounce while in FAULT -> all outputs at reset values immediately, without waiting for a clock edge.
